// File: rtl/edu_ctrl_seq.sv
// edu_ctrl_seq: self-sequencing EDU controller owning state, layer counters, token pointer and adaptive timeout
module edu_ctrl_seq #(
  parameter int CODE_DIST = 5,
  parameter int AQMEAS_TH = 2,
  parameter int NUM_ROWS = 5,
  parameter int TIMEOUT_INIT = 1,
  parameter int TIMEOUT_LIMIT = 4,
  parameter int SKIP_EN = 0,
  parameter int OPCODE_BW = 4,
  parameter logic [OPCODE_BW-1:0] RUN_ESM_OPCODE = OPCODE_BW'(4'h3),
  localparam int RB = $clog2(CODE_DIST),
  localparam int PB = $clog2(NUM_ROWS),
  localparam int TB = $clog2(TIMEOUT_LIMIT+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pchinfo_valid,
  input  logic                 pchwr_stall,
  input  logic                 pchinfo_taken,
  input  logic [OPCODE_BW-1:0] piu_opcode,
  input  logic                 aqmeas_valid,
  input  logic [NUM_ROWS-1:0]  row_head_vec,
  input  logic                 global_tokenmatch,
  input  logic                 global_errormatch,
  input  logic                 global_measmatch,
  output logic [1:0]           state,
  output logic [PB-1:0]        token_row,
  output logic [RB-1:0]        round_counter,
  output logic [TB-1:0]        timeout_th,
  output logic                 wr_pireg,
  output logic                 rst_pireg,
  output logic                 pop_aqmeasbuf,
  output logic                 shift_token,
  output logic                 token_finish,
  output logic                 layer_retry,
  output logic                 layer_finish,
  output logic                 wr_zeroesm,
  output logic                 esm_finish,
  output logic                 rst_cellstate,
  output logic                 next_valid,
  output logic                 set_measerr_flag,
  output logic                 set_last_measerr_flag,
  output logic                 apply_aqmeas_flip
);
  localparam int AB = $clog2(AQMEAS_TH+1);
  typedef enum logic [1:0] {READY, TOKENALLOC, ERRORPAIRING, WAITING} state_t;
  state_t st, st_nx;
  logic [AB-1:0] aq_cnt;
  logic [TB-1:0] timeout_cnt;
  logic [PB-1:0] skip_start, skip_next, row_start, row_next;
  logic skip_above, row_last, esm_head, in_ta, in_ep, in_idle, aq_full;
  logic go_ta, ep_exit, wait_rnd, last_rnd, load_row, adv_row;
  assign state = st;
  assign esm_head = |row_head_vec;
  assign in_ta = st == TOKENALLOC;
  assign in_ep = st == ERRORPAIRING;
  assign in_idle = st == READY || st == WAITING;
  assign aq_full = int'(aq_cnt) == AQMEAS_TH;
  assign go_ta = in_idle && aq_full;
  // descending scan leaves the lowest head overall and the lowest head above the pointer
  always_comb begin
    skip_start = '0;
    skip_next = token_row;
    skip_above = 1'b0;
    for (int i = NUM_ROWS-1; i >= 0; i--) begin
      if (row_head_vec[i]) skip_start = PB'(i);
      if (row_head_vec[i] && i > int'(token_row)) begin
        skip_next = PB'(i);
        skip_above = 1'b1;
      end
    end
  end
  assign row_start = SKIP_EN != 0 ? skip_start : '0;
  assign row_next = SKIP_EN != 0 ? skip_next : token_row + 1'b1;
  assign row_last = SKIP_EN != 0 ? ~skip_above : int'(token_row) == NUM_ROWS - 1;
  assign wr_pireg = rst_n & pchinfo_valid & (piu_opcode == RUN_ESM_OPCODE) & ~pchwr_stall;
  assign rst_pireg = rst_n & pchinfo_taken;
  assign pop_aqmeasbuf = rst_n & aqmeas_valid & in_idle & (int'(aq_cnt) < AQMEAS_TH);
  assign shift_token = in_ta;
  assign token_finish = in_ta & ~global_tokenmatch & (~esm_head | row_last);
  assign layer_retry = token_finish & esm_head & (int'(timeout_th) < TIMEOUT_LIMIT);
  assign layer_finish = token_finish & ~layer_retry;
  assign wait_rnd = int'(round_counter) < CODE_DIST - AQMEAS_TH;
  assign last_rnd = int'(round_counter) == CODE_DIST - 1;
  assign esm_finish = layer_finish & ~wait_rnd & last_rnd;
  assign next_valid = esm_finish;
  assign wr_zeroesm = layer_finish & ~wait_rnd & ~last_rnd;
  assign ep_exit = in_ep & ((timeout_cnt == timeout_th) | global_errormatch | global_measmatch);
  assign rst_cellstate = ep_exit;
  assign set_measerr_flag = token_finish & esm_head & (int'(round_counter) >= AQMEAS_TH - 1) &
                            (int'(round_counter) < CODE_DIST) & (int'(timeout_th) == TIMEOUT_LIMIT);
  assign set_last_measerr_flag = set_measerr_flag & last_rnd;
  assign apply_aqmeas_flip = st_nx == READY;
  assign load_row = go_ta | ep_exit | layer_retry | wr_zeroesm;
  assign adv_row = in_ta & ~global_tokenmatch & ~token_finish;
  always_comb begin
    st_nx = st;
    if (go_ta || ep_exit) st_nx = TOKENALLOC;
    else if (in_ta && global_tokenmatch) st_nx = ERRORPAIRING;
    else if (layer_finish) st_nx = wait_rnd ? WAITING : (last_rnd ? READY : TOKENALLOC);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= READY;
      aq_cnt <= '0;
      round_counter <= '0;
      timeout_cnt <= '0;
      timeout_th <= TB'(TIMEOUT_INIT);
      token_row <= '0;
    end else begin
      st <= st_nx;
      aq_cnt <= pop_aqmeasbuf ? aq_cnt + 1'b1 : (layer_finish && aq_cnt != '0) ? aq_cnt - 1'b1 : aq_cnt;
      round_counter <= layer_finish ? (last_rnd ? '0 : round_counter + 1'b1) : round_counter;
      timeout_cnt <= (in_ep && !ep_exit) ? timeout_cnt + 1'b1 : '0;
      timeout_th <= layer_retry ? timeout_th + 1'b1 : layer_finish ? TB'(TIMEOUT_INIT) : timeout_th;
      token_row <= load_row ? row_start : adv_row ? row_next : token_row;
    end
endmodule

// File: doc/edu_ctrl_seq.md
# edu_ctrl_seq

Parametrised, self-sequencing controller for the error decoding unit (EDU).
- Owns the EDU state register, the round / ancilla-measurement / timeout counters and the token-row pointer that the previous controller generation took as inputs.
- Adds an optional row-skipping token pass and an adaptive timeout threshold.
- Sits between the patch-info unit, the ancilla-measurement buffer and the EDU cell array.

## Interface
Parameters:
- CODE_DIST, 5, code distance; rounds per ESM = CODE_DIST
- AQMEAS_TH, 2, buffered measurement layers required before decoding
- NUM_ROWS, 5, token rows in the cell array
- TIMEOUT_INIT, 1, initial error-pairing timeout threshold
- TIMEOUT_LIMIT, 4, maximum threshold (≥ TIMEOUT_INIT)
- SKIP_EN, 0, 1 = token skips rows without ESM heads
- OPCODE_BW, 4, patch-info opcode width
- RUN_ESM_OPCODE, 4'h3, opcode that loads the patch-info register

Derived widths:
- RB = $clog2(CODE_DIST)
- PB = $clog2(NUM_ROWS)
- TB = $clog2(TIMEOUT_LIMIT+1)

Ports:
- clk in 1 — clock, all state on rising edge
- rst_n in 1 — asynchronous, active-low reset
- pchinfo_valid / pchwr_stall / pchinfo_taken in 1 each — patch-info handshake
- piu_opcode in OPCODE_BW — incoming opcode
- aqmeas_valid in 1 — measurement layer available in buffer
- row_head_vec in NUM_ROWS — bit r = row r holds an ESM head
- global_tokenmatch / global_errormatch / global_measmatch in 1 each — cell-array reductions
- state out 2 — READY=0, TOKENALLOC=1, ERRORPAIRING=2, WAITING=3
- token_row out PB — current token row
- round_counter out RB — current ESM round
- timeout_th out TB — current threshold
- wr_pireg, rst_pireg, pop_aqmeasbuf, shift_token, token_finish, layer_retry, layer_finish, wr_zeroesm, esm_finish, rst_cellstate, next_valid, set_measerr_flag, set_last_measerr_flag, apply_aqmeas_flip out 1 each — control strobes

## Operation
Registers: state, aq_cnt (0..AQMEAS_TH), round_counter, timeout_cnt, timeout_th, token_row.

Strobes are combinational (Mealy) from registers and inputs:
- esmhead_exist = |row_head_vec.
- wr_pireg = pchinfo_valid & (piu_opcode==RUN_ESM_OPCODE) & ~pchwr_stall.
- rst_pireg = pchinfo_taken.

Measurement buffering:
- pop_aqmeasbuf = aqmeas_valid & (state READY or WAITING) & (aq_cnt < AQMEAS_TH).
- Each pop increments aq_cnt.

READY/WAITING:
- Go to TOKENALLOC when aq_cnt == AQMEAS_TH.
- On entry to TOKENALLOC, token_row is loaded with the start row:
  - SKIP_EN=0: start row = 0.
  - SKIP_EN=1: start row = lowest set bit of row_head_vec, or 0 if none.

TOKENALLOC (shift_token = 1 every cycle):
- global_tokenmatch → ERRORPAIRING; token_row is held; no finish this cycle.
- token_finish asserts when either:
  - esmhead_exist = 0, or
  - token_row is the last position: NUM_ROWS-1 when SKIP_EN=0; no set bit above token_row when SKIP_EN=1.
- Otherwise token_row advances: +1 (SKIP_EN=0), or to the next set bit (SKIP_EN=1).
- layer_retry = token_finish & esmhead_exist & (timeout_th < TIMEOUT_LIMIT).
  - Effect: timeout_th += 1; token_row reloads the start row; state stays TOKENALLOC.
- layer_finish = token_finish & ~layer_retry.
  - Effects: timeout_th ← TIMEOUT_INIT; aq_cnt −1; round_counter +1, or wraps to 0 at CODE_DIST-1.
  - Next state is chosen on the pre-increment round:
    - round < CODE_DIST-AQMEAS_TH → WAITING.
    - round == CODE_DIST-1 → READY; esm_finish = 1, next_valid = 1.
    - otherwise → TOKENALLOC; wr_zeroesm = 1, token_row reloads.
- set_measerr_flag = token_finish & esmhead_exist & (AQMEAS_TH-1 ≤ round_counter < CODE_DIST) & (timeout_th == TIMEOUT_LIMIT).
- set_last_measerr_flag = set_measerr_flag & (round_counter == CODE_DIST-1).

ERRORPAIRING:
- timeout_cnt increments every cycle.
- Exit to TOKENALLOC when any of: timeout_cnt == timeout_th, global_errormatch, global_measmatch.
- On exit: rst_cellstate = 1, timeout_cnt ← 0, token_row reloads the start row.

apply_aqmeas_flip = (next state == READY).

## Timing
- Reset (async, rst_n low): state=READY, aq_cnt=0, round_counter=0, timeout_cnt=0, timeout_th=TIMEOUT_INIT, token_row=0. All strobes 0 while in reset, except apply_aqmeas_flip=1 (next state READY).
- Reset asserted mid-layer abandons the layer immediately; no strobe completes.
- State and counter updates take effect on the edge after the strobe cycle.
- A strobe shows the edge's effect in the following cycle.
- Simultaneous events:
  - global_tokenmatch wins over token_finish in the same cycle.
  - In ERRORPAIRING, the timeout and match exits are equivalent; no double pulse.
- aq_cnt saturates at AQMEAS_TH: pop suppressed when full, never decrements below 0.
- Minimum latency aq_cnt reaching threshold → first shift_token: 1 cycle.

## Test plan
1. SKIP_EN=0, row_head_vec=0, fill 2 layers:
   - TOKENALLOC for 1 cycle; token_finish=1, layer_finish=1; state→WAITING; round_counter 0→1.
2. row_head_vec=5'b00100, SKIP_EN=1, no matches:
   - token_row=2; token_finish in the first TOKENALLOC cycle.
   - layer_retry ×3 (timeout_th 1→4), then layer_finish with timeout_th reset to 1.
   - set_measerr_flag=1 only when round_counter ≥ 1.
3. global_tokenmatch at token_row=3, no error/meas match:
   - ERRORPAIRING lasts timeout_th+1 cycles; rst_cellstate pulse at exit; token_row restarts at 0.
4. round_counter=4 (CODE_DIST-1), layer_finish:
   - esm_finish=1, next_valid=1, apply_aqmeas_flip=1; state→READY; round_counter→0.
5. round_counter=3, layer_finish:
   - wr_zeroesm=1; state stays TOKENALLOC.
6. rst_n pulsed low during ERRORPAIRING:
   - All registers at reset values asynchronously.
   - pchinfo_valid=1 with opcode 4'h3 and pchwr_stall=0 → wr_pireg=1; with pchwr_stall=1 → wr_pireg=0.
